// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : opcode constants and FSM state type for the load/store unit |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lsu_pkg;

    localparam logic [6:0] OP_NOP   = 7'd0;
    localparam logic [6:0] OP_MOVI  = 7'd10;
    localparam logic [6:0] OP_LOAD  = 7'd11;
    localparam logic [6:0] OP_STORE = 7'd12;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mem : DEPTH x DATA_W storage, async read ports, multi-lane write |
// |           ports (highest lane wins) and a clear port                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                          clk,
    input  logic                          clr_en_i,
    input  logic [ADDR_W-1:0]             clr_addr_i,
    input  logic [NUM_LANES-1:0]          wr_en_i,
    input  logic [NUM_LANES*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_LANES*DATA_W-1:0]   wr_data_i,
    input  logic [NUM_LANES*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_LANES*DATA_W-1:0]   rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Later lanes overwrite earlier ones, so the highest lane wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_en_i) begin
            mem_d[clr_addr_i] = '0;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_en_i[k]) begin
                mem_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = wr_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_rd
        assign rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : multi-lane load/store/move unit with clear-on-reset |
// |   data memory. Define LSU_FORWARD_EN for same-bundle store-to-load    |
// |   forwarding.                                                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int REG_AW    = 5
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_LANES-1:0]          issueValid_i,
    output logic                          issueReady_o,
    input  logic [NUM_LANES*7-1:0]        opCode_i,
    input  logic [NUM_LANES*REG_AW-1:0]   wbAddress_i,
    input  logic [NUM_LANES*DATA_W-1:0]   pOperand_i,
    input  logic [NUM_LANES*DATA_W-1:0]   sOperand_i,
    input  logic                          stall_i,
    output logic [NUM_LANES-1:0]          wbEnable_o,
    output logic [NUM_LANES*REG_AW-1:0]   wbAddress_o,
    output logic [NUM_LANES*DATA_W-1:0]   wbData_o,
    output logic [NUM_LANES-1:0]          fault_o
);

    localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W:0]   DEPTH_EXT = (DATA_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    lsu_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]           clr_ptr_q, clr_ptr_d;
    logic [NUM_LANES-1:0]        wb_en_q, wb_en_d;
    logic [NUM_LANES-1:0]        fault_q, fault_d;
    logic [NUM_LANES*REG_AW-1:0] wb_addr_q, wb_addr_d;
    logic [NUM_LANES*DATA_W-1:0] wb_data_q, wb_data_d;

    logic                        accept;
    logic [NUM_LANES-1:0]        is_movi, is_load, is_store, in_range, mem_we;
    logic [NUM_LANES*ADDR_W-1:0] mem_addr;
    logic [NUM_LANES*DATA_W-1:0] rd_data;

    assign accept       = (state_q == RUN) && !stall_i;
    assign issueReady_o = accept;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            is_movi[k]  = issueValid_i[k] && (opCode_i[k*7 +: 7] == OP_MOVI);
            is_load[k]  = issueValid_i[k] && (opCode_i[k*7 +: 7] == OP_LOAD);
            is_store[k] = issueValid_i[k] && (opCode_i[k*7 +: 7] == OP_STORE);
            in_range[k] = {1'b0, sOperand_i[k*DATA_W +: DATA_W]} < DEPTH_EXT;
            mem_addr[k*ADDR_W +: ADDR_W] = sOperand_i[k*DATA_W +: ADDR_W];
        end
    end

    assign mem_we = {NUM_LANES{accept}} & is_store & in_range;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_ADDR) begin
                state_d   = RUN;
                clr_ptr_d = '0;
            end
        end
    end

    always_comb begin
        logic [DATA_W-1:0] ld_data;
        wb_en_d   = wb_en_q;
        fault_d   = fault_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        ld_data   = '0;
        if (!stall_i) begin
            wb_en_d   = '0;
            fault_d   = '0;
            wb_addr_d = '0;
            wb_data_d = '0;
            if (state_q == RUN) begin
                wb_addr_d = wbAddress_i;
                for (int k = 0; k < NUM_LANES; k++) begin
                    ld_data = rd_data[k*DATA_W +: DATA_W];
`ifdef LSU_FORWARD_EN
                    // Ascending scan leaves the youngest older store in ld_data.
                    for (int j = 0; j < k; j++) begin
                        if (is_store[j] && in_range[j] &&
                            mem_addr[j*ADDR_W +: ADDR_W] == mem_addr[k*ADDR_W +: ADDR_W]) begin
                            ld_data = pOperand_i[j*DATA_W +: DATA_W];
                        end
                    end
`endif
                    fault_d[k] = (is_load[k] || is_store[k]) && !in_range[k];
                    if (is_movi[k]) begin
                        wb_en_d[k] = 1'b1;
                        wb_data_d[k*DATA_W +: DATA_W] = sOperand_i[k*DATA_W +: DATA_W];
                    end else if (is_load[k] && in_range[k]) begin
                        wb_en_d[k] = 1'b1;
                        wb_data_d[k*DATA_W +: DATA_W] = ld_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            wb_en_q   <= '0;
            fault_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wb_en_q   <= wb_en_d;
            fault_q   <= fault_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    lsu_mem #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk        (clock_i),
        .clr_en_i   (state_q == CLEAR),
        .clr_addr_i (clr_ptr_q),
        .wr_en_i    (mem_we),
        .wr_addr_i  (mem_addr),
        .wr_data_i  (pOperand_i),
        .rd_addr_i  (mem_addr),
        .rd_data_o  (rd_data)
    );

    assign wbEnable_o  = wb_en_q;
    assign wbAddress_o = wb_addr_q;
    assign wbData_o    = wb_data_q;
    assign fault_o     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit : directed self-checking bench for load_store_unit |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  issue_valid;
    logic        issue_ready;
    logic [13:0] op_code;
    logic [9:0]  wb_addr_in;
    logic [31:0] p_op, s_op;
    logic        stall;
    logic [1:0]  wb_en;
    logic [9:0]  wb_addr_out;
    logic [31:0] wb_data;
    logic [1:0]  fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clock_i      (clk),
        .reset_i      (rst_n),
        .issueValid_i (issue_valid),
        .issueReady_o (issue_ready),
        .opCode_i     (op_code),
        .wbAddress_i  (wb_addr_in),
        .pOperand_i   (p_op),
        .sOperand_i   (s_op),
        .stall_i      (stall),
        .wbEnable_o   (wb_en),
        .wbAddress_o  (wb_addr_out),
        .wbData_o     (wb_data),
        .fault_o      (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = '0;
        op_code     = '0;
        wb_addr_in  = '0;
        p_op        = '0;
        s_op        = '0;
    endtask

    task automatic lane(input int k, input logic [6:0] op, input logic [4:0] rd,
                        input logic [15:0] p, input logic [15:0] s);
        issue_valid[k]       = 1'b1;
        op_code[k*7 +: 7]    = op;
        wb_addr_in[k*5 +: 5] = rd;
        p_op[k*16 +: 16]     = p;
        s_op[k*16 +: 16]     = s;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        idle();
        tick();
        tick();
        chk("reset_wb_en", 32'(wb_en), 32'h0);
        chk("reset_wb_data", wb_data, 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_ready", 32'(issue_ready), 32'h0);

        // Release reset: exactly 8 cycles not ready.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clear_ready_low_%0d", i), 32'(issue_ready), 32'h0);
            tick();
        end
        chk("clear_ready_high", 32'(issue_ready), 32'h1);

        lane(0, OP_LOAD, 5'd1, 16'h0, 16'd5);
        tick();
        idle();
        chk("load5_wb_en", 32'(wb_en), 32'h1);
        chk("load5_wb_data", 32'(wb_data[15:0]), 32'h0);
        tick();
        chk("idle_wb_en", 32'(wb_en), 32'h0);

        // Store then load from lane 1.
        lane(0, OP_STORE, 5'd0, 16'hBEEF, 16'd3);
        tick();
        idle();
        chk("store_no_wb", 32'(wb_en), 32'h0);
        chk("store_no_fault", 32'(fault), 32'h0);
        lane(1, OP_LOAD, 5'd7, 16'h0, 16'd3);
        tick();
        idle();
        chk("basic_wb_en", 32'(wb_en), 32'h2);
        chk("basic_wb_addr1", 32'(wb_addr_out[9:5]), 32'd7);
        chk("basic_wb_data1", 32'(wb_data[31:16]), 32'hBEEF);
        chk("basic_wb_data0", 32'(wb_data[15:0]), 32'h0);

        // Same-bundle store/load to address 2.
        lane(0, OP_STORE, 5'd0, 16'h1234, 16'd2);
        lane(1, OP_LOAD, 5'd3, 16'h0, 16'd2);
        tick();
        idle();
        chk("fwd_wb_en", 32'(wb_en), 32'h2);
`ifdef LSU_FORWARD_EN
        chk("fwd_data", 32'(wb_data[31:16]), 32'h1234);
`else
        chk("fwd_data", 32'(wb_data[31:16]), 32'h0000);
`endif
        lane(0, OP_LOAD, 5'd3, 16'h0, 16'd2);
        tick();
        idle();
        chk("fwd_store_landed", 32'(wb_data[15:0]), 32'h1234);

        // Same-address store collision.
        lane(0, OP_STORE, 5'd0, 16'hAAAA, 16'd4);
        lane(1, OP_STORE, 5'd0, 16'h5555, 16'd4);
        tick();
        idle();
        lane(0, OP_LOAD, 5'd2, 16'h0, 16'd4);
        tick();
        idle();
        chk("collision_data", 32'(wb_data[15:0]), 32'h5555);

        // Range faults.
        lane(1, OP_LOAD, 5'd2, 16'h0, 16'd8);
        tick();
        idle();
        chk("load8_fault", 32'(fault), 32'h2);
        chk("load8_wb_en", 32'(wb_en), 32'h0);
        chk("load8_wb_data", wb_data, 32'h0);
        lane(0, OP_STORE, 5'd0, 16'hDEAD, 16'd9);
        tick();
        idle();
        chk("store9_fault", 32'(fault), 32'h1);
        lane(0, OP_LOAD, 5'd2, 16'h0, 16'd1);
        tick();
        idle();
        chk("store9_no_alias", 32'(wb_data[15:0]), 32'h0);
        chk("load1_no_fault", 32'(fault), 32'h0);

        // Invalid lane ignored.
        lane(0, OP_STORE, 5'd0, 16'h9999, 16'd6);
        issue_valid = 2'b00;
        tick();
        idle();
        chk("invalid_no_fault", 32'(fault), 32'h0);
        lane(1, OP_LOAD, 5'd5, 16'h0, 16'd6);
        tick();
        idle();
        chk("invalid_not_written", 32'(wb_data[31:16]), 32'h0);

        // MOVI with large immediate then stall.
        lane(0, OP_MOVI, 5'd4, 16'h0, 16'h00FF);
        tick();
        idle();
        chk("movi_wb_en", 32'(wb_en), 32'h1);
        chk("movi_data", 32'(wb_data[15:0]), 32'h00FF);
        chk("movi_no_fault", 32'(fault), 32'h0);
        stall = 1'b1;
        lane(1, OP_STORE, 5'd0, 16'h7777, 16'd6);
        #1;
        chk("stall_ready_low", 32'(issue_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold_en_%0d", i), 32'(wb_en), 32'h1);
            chk($sformatf("stall_hold_data_%0d", i), 32'(wb_data[15:0]), 32'h00FF);
            chk($sformatf("stall_hold_addr_%0d", i), 32'(wb_addr_out[4:0]), 32'd4);
        end
        stall = 1'b0;
        idle();
        tick();
        chk("unstall_idle_en", 32'(wb_en), 32'h0);
        lane(0, OP_LOAD, 5'd1, 16'h0, 16'd6);
        tick();
        idle();
        chk("stalled_store_dropped", 32'(wb_data[15:0]), 32'h0);

        // Reset mid-RUN discards an in-flight bundle; then reset mid-CLEAR.
        lane(0, OP_STORE, 5'd0, 16'h0777, 16'd7);
        tick();
        idle();
        lane(0, OP_MOVI, 5'd9, 16'h0, 16'h0055);
        rst_n = 1'b0;
        tick();
        idle();
        chk("reset_run_wb_en", 32'(wb_en), 32'h0);
        chk("reset_run_wb_data", wb_data, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reclear_ready_low_%0d", i), 32'(issue_ready), 32'h0);
            tick();
        end
        chk("reclear_ready_high", 32'(issue_ready), 32'h1);
        lane(0, OP_LOAD, 5'd1, 16'h0, 16'd7);
        lane(1, OP_LOAD, 5'd2, 16'h0, 16'd3);
        tick();
        idle();
        chk("reclear_addr7", 32'(wb_data[15:0]), 32'h0);
        chk("reclear_addr3", 32'(wb_data[31:16]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of issue lanes; lane 0 is oldest in program order.
REQ-002 SHALL have parameter DATA_W, default 16, data and operand width.
REQ-003 SHALL have parameter DEPTH, default 8, data-memory words; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have parameter REG_AW, default 5, writeback register-address width.
REQ-005 SHALL have port clock_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port issueValid_i, input, NUM_LANES, per-lane instruction valid.
REQ-008 SHALL have port issueReady_o, output, 1, bundle accepted on any edge where it is high.
REQ-009 SHALL have port opCode_i, input, NUM_LANES*7, packed per-lane opcode.
REQ-010 SHALL have port wbAddress_i, input, NUM_LANES*REG_AW, per-lane destination register.
REQ-011 SHALL have ports pOperand_i and sOperand_i, input, NUM_LANES*DATA_W each; pOperand is store data, sOperand is address or immediate.
REQ-012 SHALL have port stall_i, input, 1, writeback backpressure.
REQ-013 SHALL have ports wbEnable_o (NUM_LANES), wbAddress_o (NUM_LANES*REG_AW) and wbData_o (NUM_LANES*DATA_W), all outputs, per-lane registered writeback.
REQ-014 SHALL have port fault_o, output, NUM_LANES, per-lane address-range fault, registered alongside writeback.

Function
REQ-015 SHALL decode opcodes as follows: 0 NOP; 10 MOVI (writeback sOperand); 11 LOAD (writeback mem[sOperand]); 12 STORE (mem[sOperand] <= pOperand, no writeback); any other opcode is treated as NOP with no fault.
REQ-016 SHALL use a two-state FSM: CLEAR (after reset, writes 0 to address clrPtr each cycle, issueReady_o=0, clrPtr 0..DEPTH-1) -> RUN when clrPtr reaches DEPTH-1.
REQ-017 SHALL drive issueReady_o = (state==RUN) & ~stall_i.
REQ-018 SHALL register the result of an accepted bundle onto the wb*/fault_o outputs on the next edge (latency 1 cycle).
REQ-019 SHALL, on an edge with no bundle accepted and stall_i=0, drive wbEnable_o=0 and fault_o=0.
REQ-020 SHALL hold all wb*/fault_o outputs unchanged and perform no memory write while stall_i=1.
REQ-021 SHALL ignore lanes whose issueValid_i is 0: no writeback, no write, no fault.
REQ-022 SHALL flag an out-of-range access (LOAD or STORE with sOperand >= DEPTH): set fault_o[k]=1, wbEnable_o[k]=0 and suppress the write; MOVI never faults.
REQ-023 SHALL apply multiple same-cycle STOREs to the same address so that the highest-numbered lane wins.
REQ-024 SHALL return data from a LOAD in lane k according to REQ-032/REQ-033.
REQ-025 SHALL drive wbData_o[k]=0 for NOP, STORE and faulting lanes.

Reset
REQ-026 SHALL, while reset_i=0 at an edge, clear wbEnable_o, wbAddress_o, wbData_o and fault_o to 0, set clrPtr=0 and set the state to CLEAR.
REQ-027 SHALL make reset asserted mid-CLEAR or mid-RUN discard in-flight results and restart CLEAR from address 0.
REQ-028 SHALL hold issueReady_o=0 for exactly DEPTH cycles after reset deasserts.

Configuration
REQ-029 SHALL compile store-to-load forwarding in or out with macro LSU_FORWARD_EN.
REQ-030 SHALL, when LSU_FORWARD_EN is defined, make a LOAD in lane k return the pOperand of the highest lane j<k in the same bundle that is a valid, non-faulting STORE to the same address, else mem[sOperand].
REQ-031 SHALL, when LSU_FORWARD_EN is undefined, make every LOAD return memory contents from before the bundle.
REQ-032 SHALL, with LSU_FORWARD_EN defined, return forwarded-or-memory data as in REQ-030.
REQ-033 SHALL, with LSU_FORWARD_EN undefined, return pre-bundle data as in REQ-031.

Structure
REQ-034 SHALL place opcode constants (OP_NOP, OP_MOVI, OP_LOAD, OP_STORE) and the state enum (CLEAR, RUN) in shared package lsu_pkg.
REQ-035 SHALL contain the storage in a single sub-module lsu_mem: DEPTH x DATA_W, NUM_LANES asynchronous read ports and NUM_LANES write ports with highest-lane-wins priority, plus a clear port.

Verification
REQ-036 SHALL test reset: release reset -> issueReady_o low for 8 cycles, then high; LOAD addr 5 -> wbData 0.
REQ-037 SHALL test basic operation: lane0 STORE 0xBEEF@3, next bundle lane1 LOAD @3 to r7 -> next cycle wbEnable=2'b10, wbAddress[1]=7, wbData[1]=0xBEEF.
REQ-038 SHALL test forwarding: lane0 STORE 0x1234@2, lane1 LOAD @2 in the same bundle -> 0x1234 with LSU_FORWARD_EN defined, prior value 0x0000 without it.
REQ-039 SHALL test write collision: lane0 STORE 0xAAAA@4, lane1 STORE 0x5555@4 -> later LOAD @4 returns 0x5555.
REQ-040 SHALL test range fault: LOAD @8 (DEPTH=8) -> fault_o[k]=1, wbEnable_o[k]=0; STORE @9 -> fault and memory unchanged.
REQ-041 SHALL test stall: assert stall_i for 3 cycles after MOVI 0x00FF -> outputs held, issueReady_o=0, stalled STORE not written; reset mid-CLEAR -> CLEAR restarts at address 0.
